// File: rtl/multi_pulser_pkg.sv
// rtl/multi_pulser_pkg.sv - shared state encoding and defaults for multi_pulser
package multi_pulser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEFAULT_LEN_W = 8;

endpackage

// File: rtl/pulse_channel.sv
// rtl/pulse_channel.sv - one assertion-to-pulse channel with overrun flag
// Optional input synchroniser enabled by MULTI_PULSER_SYNC_EN.
module pulse_channel
   import multi_pulser_pkg::*;
#(
   parameter int   LEN_W = DEFAULT_LEN_W,
   parameter logic POL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_lvl,
   input  logic [LEN_W-1:0] pulse_len,
   input  logic             ovr_clr,
   output logic             out,
   output logic             busy,
   output logic             overrun
);

   logic a;

`ifdef MULTI_PULSER_SYNC_EN
   logic sync1, sync2;

   // Sync flops reset to the deasserted level so reset release is not a trigger.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= POL;
         sync2 <= POL;
      end else begin
         sync1 <= in_lvl;
         sync2 <= sync1;
      end
   end

   assign a = sync2 ^ POL;
`else
   assign a = in_lvl ^ POL;
`endif

   state_t           state, state_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic             a_prev;
   logic             ovr_set;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ovr_set   = (state == PULSE) && a && !a_prev;
      case (state)
         IDLE: begin
            if (a) begin
               state_nxt = PULSE;
               cnt_nxt   = (pulse_len == '0) ? '0 : pulse_len - LEN_W'(1);
            end
         end
         PULSE: begin
            if (cnt == '0) state_nxt = HOLD;
            else           cnt_nxt   = cnt - LEN_W'(1);
         end
         HOLD: begin
            if (!a) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         a_prev  <= 1'b0;
         out     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         a_prev  <= a;
         out     <= (state_nxt == PULSE);
         // A new overrun event beats a simultaneous clear.
         overrun <= ovr_set | (overrun & ~ovr_clr);
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/multi_pulser.sv
// rtl/multi_pulser.sv - multi-channel assertion-to-pulse generator (MULTI_PULSER_SYNC_EN adds input sync)
module multi_pulser
   import multi_pulser_pkg::*;
#(
   parameter int                  CHANNELS = 4,
   parameter int                  LEN_W    = DEFAULT_LEN_W,
   parameter logic [CHANNELS-1:0] POLARITY = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in,
   input  logic [LEN_W-1:0]    pulse_len,
   input  logic                ovr_clr,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] overrun
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pulse_channel #(
         .LEN_W (LEN_W),
         .POL   (POLARITY[g])
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .in_lvl    (in[g]),
         .pulse_len (pulse_len),
         .ovr_clr   (ovr_clr),
         .out       (out[g]),
         .busy      (busy[g]),
         .overrun   (overrun[g])
      );
   end

endmodule
